gpr_wb_ctrl: RTL and testbench

GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

---
 rtl/gpr_wb_ctrl.sv | 123 ++++++++++++
 tb/tb_gpr_wb_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_ctrl.sv
// Register-file write-back arbiter: merges ALU results with in-order load returns,
// tracking outstanding load destinations in a tag FIFO and a pending scoreboard.
module gpr_wb_ctrl #(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_addr,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       ld_issue,
    input  logic [4:0]                 ld_addr,
    output logic                       ld_issue_ready,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic                       we,
    output logic [4:0]                 wr_addr,
    output logic [31:0]                wr_data,
    input  logic [4:0]                 rd_addr_0,
    input  logic [4:0]                 rd_addr_1,
    output logic                       stall,
    output logic [$clog2(LQ_DEPTH):0]  lq_count,
    output logic                       err
);

    localparam int unsigned PW = $clog2(LQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    tags [LQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;
    logic          err_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          alu_fire;
    logic          ret_err;
    logic [4:0]    head;

    assign full  = (count == CW'(LQ_DEPTH));
    assign empty = (count == '0);
    assign head  = tags[rd_ptr];

    // Handshakes use registered pending state only; load return outranks the ALU.
    assign ld_issue_ready = ~rst & ~full & ~pending[ld_addr];
    assign alu_ready      = ~rst & ~mem_rvalid & ~pending[alu_addr];

    assign push     = ld_issue & ld_issue_ready;
    assign pop      = ~rst & mem_rvalid & ~empty;
    assign ret_err  = ~rst & mem_rvalid & empty;
    assign alu_fire = alu_valid & alu_ready;

    // Write-port mux
    always_comb begin
        we      = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        if (pop) begin
            we      = 1'b1;
            wr_addr = head;
            wr_data = mem_rdata;
        end else if (alu_fire) begin
            we      = 1'b1;
            wr_addr = alu_addr;
            wr_data = alu_data;
        end
    end

    // A same-cycle write to a source register is forwarded by the register file.
    assign stall = ~rst &
                   ((pending[rd_addr_0] & ~(we & (wr_addr == rd_addr_0))) |
                    (pending[rd_addr_1] & ~(we & (wr_addr == rd_addr_1))));

    // Push after pop so a same-register retire/issue leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (pop) begin
            pending_nxt[head] = 1'b0;
        end
        if (push) begin
            pending_nxt[ld_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count + CW'(push) - CW'(pop);
            pending <= pending_nxt;
            if (ret_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= ld_addr;
        end
    end

    assign lq_count = count;
    assign err      = err_q & ~rst;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed per-cycle vectors for gpr_wb_ctrl: inputs are applied after each rising
// edge and all outputs are compared mid-cycle against hand-computed values.
module tb_gpr_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_addr;
    logic        ld_issue_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_0;
    logic [4:0]  rd_addr_1;
    logic        stall;
    logic [2:0]  lq_count;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpr_wb_ctrl #(.LQ_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_addr        (ld_addr),
        .ld_issue_ready (ld_issue_ready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .we             (we),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_addr_0      (rd_addr_0),
        .rd_addr_1      (rd_addr_1),
        .stall          (stall),
        .lq_count       (lq_count),
        .err            (err)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        li;
        logic [4:0]  la;
        logic        mv;
        logic [31:0] md;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_ar;
        logic        e_lir;
        logic        e_st;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_i, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic li, input logic [4:0] la, input logic mv, input logic [31:0] md,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_ar, input logic e_lir, input logic e_st, input logic [2:0] e_cnt,
        input logic e_err);
        vec_t v;
        v.rst = rst_i; v.av = av; v.aa = aa; v.ad = ad; v.li = li; v.la = la;
        v.mv = mv; v.md = md; v.r0 = r0; v.r1 = r1;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_ar = e_ar;
        v.e_lir = e_lir; v.e_st = e_st; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step%0d %s: got=%h expected=%h", step, nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance past the next edge.
    task automatic apply(input int step, input vec_t v);
        rst = v.rst; alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        ld_issue = v.li; ld_addr = v.la; mem_rvalid = v.mv; mem_rdata = v.md;
        rd_addr_0 = v.r0; rd_addr_1 = v.r1;
        #3;
        chk("we",             step, 32'(we),             32'(v.e_we));
        chk("wr_addr",        step, 32'(wr_addr),        32'(v.e_wa));
        chk("wr_data",        step, wr_data,             v.e_wd);
        chk("alu_ready",      step, 32'(alu_ready),      32'(v.e_ar));
        chk("ld_issue_ready", step, 32'(ld_issue_ready), 32'(v.e_lir));
        chk("stall",          step, 32'(stall),          32'(v.e_st));
        chk("lq_count",       step, 32'(lq_count),       32'(v.e_cnt));
        chk("err",            step, 32'(err),            32'(v.e_err));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [16];

    initial begin
        //              rst av aa  ad            li la  mv md     r0  r1   we wa  wd            ar lir st cnt err
        tbl[0]  = mk(1, 1, 5,  32'h1234_5678, 0, 0,  1, 32'hEE, 3,  0,   0, 0,  32'h0,         0, 0,  0, 0, 0);
        tbl[1]  = mk(0, 1, 5,  32'h1234_5678, 0, 0,  0, 32'h0,  0,  0,   1, 5,  32'h1234_5678, 1, 1,  0, 0, 0);
        tbl[2]  = mk(0, 0, 0,  32'h0,         1, 3,  0, 32'h0,  0,  0,   0, 0,  32'h0,         1, 1,  0, 0, 0);
        tbl[3]  = mk(0, 0, 0,  32'h0,         1, 7,  0, 32'h0,  3,  0,   0, 0,  32'h0,         1, 1,  1, 1, 0);
        tbl[4]  = mk(0, 0, 0,  32'h0,         1, 3,  0, 32'h0,  3,  7,   0, 0,  32'h0,         1, 0,  1, 2, 0);
        tbl[5]  = mk(0, 1, 9,  32'h99,        0, 0,  1, 32'hAA, 3,  0,   1, 3,  32'hAA,        0, 1,  0, 2, 0);
        tbl[6]  = mk(0, 1, 9,  32'h99,        0, 0,  0, 32'h0,  7,  0,   1, 9,  32'h99,        1, 1,  1, 1, 0);
        tbl[7]  = mk(0, 1, 7,  32'h55,        0, 0,  0, 32'h0,  0,  0,   0, 0,  32'h0,         0, 1,  0, 1, 0);
        tbl[8]  = mk(0, 0, 0,  32'h0,         1, 0,  1, 32'hBB, 7,  0,   1, 7,  32'hBB,        0, 1,  0, 1, 0);
        tbl[9]  = mk(0, 1, 0,  32'h44,        0, 0,  0, 32'h0,  0,  0,   0, 0,  32'h0,         0, 0,  1, 1, 0);
        tbl[10] = mk(0, 0, 0,  32'h0,         0, 0,  1, 32'hCC, 0,  0,   1, 0,  32'hCC,        0, 0,  0, 1, 0);
        tbl[11] = mk(0, 0, 0,  32'h0,         0, 0,  1, 32'hDD, 0,  0,   0, 0,  32'h0,         0, 1,  0, 0, 0);
        tbl[12] = mk(0, 0, 0,  32'h0,         0, 0,  0, 32'h0,  0,  0,   0, 0,  32'h0,         1, 1,  0, 0, 1);
        tbl[13] = mk(0, 1, 2,  32'h1,         0, 0,  0, 32'h0,  0,  0,   1, 2,  32'h1,         1, 1,  0, 0, 1);
        tbl[14] = mk(1, 0, 0,  32'h0,         0, 0,  0, 32'h0,  0,  0,   0, 0,  32'h0,         0, 0,  0, 0, 0);
        tbl[15] = mk(0, 0, 0,  32'h0,         0, 0,  0, 32'h0,  0,  0,   0, 0,  32'h0,         1, 1,  0, 0, 0);

        rst = 1'b1; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_issue = 1'b0; ld_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        rd_addr_0 = '0; rd_addr_1 = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            apply(i, tbl[i]);
        end

        // Fill to full, refused issue while full, concurrent retire+issue, drain in order.
        apply(100, mk(0, 0, 0, 0, 1, 1, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 0, 0));
        apply(101, mk(0, 0, 0, 0, 1, 2, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 1, 0));
        apply(102, mk(0, 0, 0, 0, 1, 3, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 2, 0));
        apply(103, mk(0, 0, 0, 0, 1, 4, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 3, 0));
        apply(104, mk(0, 0, 0, 0, 1, 5, 1, 32'h11, 0, 0, 1, 1, 32'h11, 0, 0, 0, 4, 0));
        apply(105, mk(0, 0, 0, 0, 1, 5, 1, 32'h22, 0, 0, 1, 2, 32'h22, 0, 1, 0, 3, 0));
        apply(106, mk(0, 0, 0, 0, 1, 6, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 3, 0));
        apply(107, mk(0, 0, 0, 0, 1, 7, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 4, 0));
        apply(108, mk(0, 0, 0, 0, 0, 0, 1, 32'h33, 0, 0, 1, 3, 32'h33, 0, 0, 0, 4, 0));
        apply(109, mk(0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0, 1, 4, 32'h44, 0, 1, 0, 3, 0));
        apply(110, mk(0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 1, 5, 32'h55, 0, 1, 0, 2, 0));
        apply(111, mk(0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 1, 6, 32'h66, 0, 1, 0, 1, 0));
        apply(112, mk(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 0, 0));

        // Reset with loads outstanding: tags dropped, late return flags err.
        apply(200, mk(0, 0, 0,  0,     1, 10, 0, 0,      0,  0, 0, 0,  0,     1, 1, 0, 0, 0));
        apply(201, mk(0, 0, 0,  0,     1, 11, 0, 0,      10, 0, 0, 0,  0,     1, 1, 1, 1, 0));
        apply(202, mk(1, 0, 0,  0,     0, 0,  0, 0,      10, 0, 0, 0,  0,     0, 0, 0, 2, 0));
        apply(203, mk(0, 0, 0,  0,     0, 0,  1, 32'h77, 10, 0, 0, 0,  0,     0, 1, 0, 0, 0));
        apply(204, mk(0, 1, 10, 32'h5, 0, 0,  0, 0,      0,  0, 1, 10, 32'h5, 1, 1, 0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
